// File: rtl/conv_bias_fifo_rd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_bias_fifo_rd_pkg
//  Description : Shared definitions for the Bias FIFO consumer. Covers the
//                bias entry field layout, FSM state encoding, the total-count
//                width and the entries-per-instruction helper.
//  Revision    : 1.0  initial release
// ============================================================================
package conv_bias_fifo_rd_pkg;

    localparam int CNT_W     = 32;
    localparam int ENTRY_W   = 64;
    localparam int BIAS_LSB  = 0;
    localparam int BIAS_W    = 32;
    localparam int SCALE_LSB = 32;
    localparam int SCALE_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Entries consumed by one instruction: X rounds * W rounds * channels
    function automatic logic [CNT_W-1:0] total_entries(
        input logic [15:0]      nx_m1,
        input logic [15:0]      nw_m1,
        input logic [CNT_W-1:0] m
    );
        logic [CNT_W-1:0] nx;
        logic [CNT_W-1:0] nw;
        nx = CNT_W'(nx_m1) + CNT_W'(1);
        nw = CNT_W'(nw_m1) + CNT_W'(1);
        return nx * nw * m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_bias_fifo_rd_buf.sv
`default_nettype none
// ============================================================================
//  Module      : conv_bias_buf
//  Description : Small register FIFO holding popped bias entries until the
//                post-processing stage accepts them. Head is always visible;
//                occupancy is exported so the caller can budget credits.
//  Revision    : 1.0  initial release
// ============================================================================
module conv_bias_buf #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             w_rd;

    // Pops are ignored when empty so a stray ready can never underflow
    assign w_rd    = rd_en_i && (count_q != '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage, pointers and occupancy; simultaneous push+pop keeps count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr_en_i) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (w_rd) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({wr_en_i, w_rd})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_bias_fifo_rd.sv
`default_nettype none
// ============================================================================
//  Module      : conv_bias_fifo_rd
//  Description : Bias FIFO consumer. Issues credit-limited pops, buffers the
//                returning entries and presents bias/scale per output channel
//                with channel and last tags. Optional sticky protocol checker
//                enabled by defining CONV_BIAS_RD_CHK_EN (adds port err).
//  Revision    : 1.0  initial release
// ============================================================================
`ifndef M
`define M 4
`endif

module conv_bias_fifo_rd
    import conv_bias_fifo_rd_pkg::*;
#(
    parameter int  M         = `M,
    parameter int  BUF_DEPTH = 4,
    localparam int MW        = (M > 1) ? $clog2(M) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_pulse,
    input  logic [15:0]   n_X_rnd_minus_1,
    input  logic [15:0]   n_W_rnd_minus_1,
    output logic          fifo_rd_en,
    input  logic [63:0]   fifo_dout,
    input  logic          fifo_empty,
    output logic          bias_vld,
    input  logic          bias_rdy,
    output logic [31:0]   bias,
    output logic [31:0]   scale,
    output logic [MW-1:0] m_idx,
    output logic          last_m,
    output logic          last,
    output logic          busy,
    output logic          done_pulse
`ifdef CONV_BIAS_RD_CHK_EN
    ,
    output logic          err
`endif
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int PW = AW + 2;
    localparam logic [MW-1:0]    M_LAST  = MW'(M - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e             state_q;
    logic [CNT_W-1:0]   rd_left_q;
    logic [CNT_W-1:0]   out_left_q;
    logic [MW-1:0]      m_idx_q;
    logic               rd_en_q;
    logic               rd_vld_q;
    logic               busy_q;
    logic               done_q;

    logic [AW:0]        w_occ;
    logic [ENTRY_W-1:0] w_head;
    logic [PW-1:0]      w_pending;
    logic               w_has_credit;
    logic               w_pop;
    logic [CNT_W-1:0]   w_total;

    assign w_total = total_entries(n_X_rnd_minus_1, n_W_rnd_minus_1, CNT_W'(M));

    // Buffer slots already spoken for: stored, being read now, landing now
    assign w_pending    = PW'(w_occ) + PW'(rd_en_q) + PW'(rd_vld_q);
    assign w_has_credit = w_pending < PW'(BUF_DEPTH);

    assign bias_vld   = (w_occ != '0);
    assign w_pop      = bias_vld && bias_rdy;
    assign bias       = w_head[BIAS_LSB  +: BIAS_W];
    assign scale      = w_head[SCALE_LSB +: SCALE_W];
    assign m_idx      = m_idx_q;
    assign last_m     = bias_vld && (m_idx_q == M_LAST);
    assign last       = bias_vld && (out_left_q == CNT_ONE);
    assign fifo_rd_en = rd_en_q;
    assign busy       = busy_q;
    assign done_pulse = done_q;

    // FIFO data is valid one cycle after the pop, so it lands on rd_vld_q
    conv_bias_buf #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (rd_vld_q),
        .wr_data_i (fifo_dout),
        .rd_en_i   (w_pop),
        .head_o    (w_head),
        .count_o   (w_occ)
    );

    // Instruction FSM, read issue, output counters and channel index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rd_left_q  <= '0;
            out_left_q <= '0;
            m_idx_q    <= '0;
            rd_en_q    <= 1'b0;
            rd_vld_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            rd_en_q  <= 1'b0;
            rd_vld_q <= rd_en_q;
            done_q   <= 1'b0;
            if (w_pop) begin
                out_left_q <= out_left_q - CNT_ONE;
                m_idx_q    <= (m_idx_q == M_LAST) ? '0 : m_idx_q + MW'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_pulse) begin
                        state_q    <= ST_RUN;
                        busy_q     <= 1'b1;
                        out_left_q <= w_total;
                        m_idx_q    <= '0;
                        // First read goes out the cycle after start
                        if (!fifo_empty && (w_total != '0) && w_has_credit) begin
                            rd_en_q   <= 1'b1;
                            rd_left_q <= w_total - CNT_ONE;
                        end else begin
                            rd_left_q <= w_total;
                        end
                    end
                end
                ST_RUN: begin
                    if (rd_left_q == '0) begin
                        state_q <= ST_DRAIN;
                    end else if (!fifo_empty && w_has_credit) begin
                        rd_en_q   <= 1'b1;
                        rd_left_q <= rd_left_q - CNT_ONE;
                    end
                end
                ST_DRAIN: begin
                    // Enter DONE on the final handshake so the pulse follows it
                    if ((out_left_q == '0) || (w_pop && (out_left_q == CNT_ONE))) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef CONV_BIAS_RD_CHK_EN
    logic err_q;

    // Sticky protocol error: restart while busy, pop on empty, leftover bias
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((start_pulse && (state_q != ST_IDLE)) ||
                     (rd_en_q && fifo_empty) ||
                     ((state_q == ST_DONE) && !fifo_empty)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_bias_fifo_rd.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_conv_bias_fifo_rd
//  Description : Directed self-checking bench for conv_bias_fifo_rd with a
//                standard-mode FIFO model and an in-order scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_conv_bias_fifo_rd;

    localparam int M         = 4;
    localparam int BUF_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_pulse;
    logic [15:0] n_x;
    logic [15:0] n_w;
    logic        fifo_rd_en;
    logic [63:0] fifo_dout;
    logic        fifo_empty;
    logic        bias_vld;
    logic        bias_rdy;
    logic [31:0] bias;
    logic [31:0] scale;
    logic [1:0]  m_idx;
    logic        last_m;
    logic        last;
    logic        busy;
    logic        done_pulse;
`ifdef CONV_BIAS_RD_CHK_EN
    logic        err;
`endif

    conv_bias_fifo_rd #(
        .M         (M),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_pulse     (start_pulse),
        .n_X_rnd_minus_1 (n_x),
        .n_W_rnd_minus_1 (n_w),
        .fifo_rd_en      (fifo_rd_en),
        .fifo_dout       (fifo_dout),
        .fifo_empty      (fifo_empty),
        .bias_vld        (bias_vld),
        .bias_rdy        (bias_rdy),
        .bias            (bias),
        .scale           (scale),
        .m_idx           (m_idx),
        .last_m          (last_m),
        .last            (last),
        .busy            (busy),
        .done_pulse      (done_pulse)
`ifdef CONV_BIAS_RD_CHK_EN
        ,
        .err             (err)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Cycle counter
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Standard-mode FIFO model: data appears the cycle after the pop
    logic [63:0] fifo_mem [16];
    int          fifo_n = 0;
    int          rd_ptr;
    logic        fifo_clr;
    logic        force_empty;
    always @(posedge clk) begin
        if (fifo_clr) begin
            rd_ptr <= 0;
        end else if (fifo_rd_en && (rd_ptr < fifo_n)) begin
            fifo_dout <= fifo_mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end
    assign fifo_empty = force_empty || (rd_ptr >= fifo_n);

    // Downstream ready: always high, or the 1,0,0,1 backpressure pattern
    logic       bp_mode;
    logic [3:0] bp_pat = 4'b1001;
    int         bp_i = 0;
    always @(posedge clk) begin
        #1;
        if (bp_mode) begin
            bias_rdy = bp_pat[bp_i];
            bp_i     = (bp_i + 1) % 4;
        end else begin
            bias_rdy = 1'b1;
        end
    end

    // Scoreboard / monitor sampled on the falling edge
    logic        sb_clr;
    int          t_exp = 8;
    int          sb_idx, rd_cnt, max_out;
    int          first_rd_cyc, first_vld_cyc, first_hs_cyc, last_hs_cyc;
    logic [31:0] first_bias, first_scale;
    logic        stall_hold;
    logic [63:0] held;
    int          done_cnt = 0;
    always @(negedge clk) begin
        if (sb_clr) begin
            sb_idx = 0; rd_cnt = 0; max_out = 0;
            first_rd_cyc = -1; first_vld_cyc = -1; first_hs_cyc = -1; last_hs_cyc = -1;
            stall_hold = 1'b0; first_bias = '0; first_scale = '0;
        end else if (rst_n) begin
            if (fifo_rd_en) begin
                rd_cnt++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
            end
            if (rd_cnt - sb_idx > max_out) max_out = rd_cnt - sb_idx;
            if (bias_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (stall_hold) begin
                check_eq("stall_vld", 64'(bias_vld), 64'd1);
                check_eq("stall_data", {scale, bias}, held);
            end
            if (bias_vld && bias_rdy) begin
                if (sb_idx >= t_exp) begin
                    check_eq("entry_count", 64'(sb_idx + 1), 64'(t_exp));
                end else begin
                    check_eq("data", {scale, bias}, fifo_mem[sb_idx]);
                    check_eq("m_idx", 64'(m_idx), 64'(sb_idx % M));
                    check_eq("last_m", 64'(last_m), 64'((sb_idx % M) == M - 1));
                    check_eq("last", 64'(last), 64'(sb_idx == t_exp - 1));
                end
                if (first_hs_cyc < 0) begin
                    first_hs_cyc = cyc;
                    first_bias   = bias;
                    first_scale  = scale;
                end
                last_hs_cyc = cyc;
                sb_idx++;
            end
            stall_hold = bias_vld && !bias_rdy;
            held       = {scale, bias};
            if (done_pulse) begin
                done_cnt++;
                check_eq("done_latency", 64'(cyc - last_hs_cyc), 64'd1);
            end
        end
    end

    task automatic load_fifo(input int n, input logic [31:0] tag);
        fifo_clr = 1'b1;
        @(posedge clk); #1;
        fifo_clr = 1'b0;
        for (int i = 0; i < n; i++) fifo_mem[i] = {32'h0000_0100 + 32'(i), tag + 32'(i)};
        fifo_n = n;
    endtask

    task automatic sb_reset(input int t);
        t_exp  = t;
        sb_clr = 1'b1;
        @(negedge clk); #1;
        sb_clr = 1'b0;
    endtask

    int start_cyc;
    task automatic start_instr(input logic [15:0] nx, input logic [15:0] nw);
        n_x = nx;
        n_w = nw;
        @(posedge clk); #1;
        start_pulse = 1'b1;
        start_cyc   = cyc;
        @(posedge clk); #1;
        start_pulse = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_pulse) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq(tag, 64'(seen), 64'd1);
    endtask

    int hi_cnt;
    int dc_before;

    initial begin
        rst_n = 1'b0; start_pulse = 1'b0; n_x = '0; n_w = '0;
        fifo_clr = 1'b1; force_empty = 1'b0; sb_clr = 1'b1; bp_mode = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        check_eq("rst_vld",   64'(bias_vld),   64'd0);
        check_eq("rst_bias",  64'(bias),       64'd0);
        check_eq("rst_scale", 64'(scale),      64'd0);
        check_eq("rst_m_idx", 64'(m_idx),      64'd0);
        check_eq("rst_last_m",64'(last_m),     64'd0);
        check_eq("rst_last",  64'(last),       64'd0);
        check_eq("rst_busy",  64'(busy),       64'd0);
        check_eq("rst_done",  64'(done_pulse), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        fifo_clr = 1'b0;

        // Back-to-back run, T = 1*2*4 = 8, with the bias/scale split entry first
        load_fifo(8, 32'hA000_0000);
        fifo_mem[0] = 64'h0000_0100_FFFF_FFF6;
        sb_reset(8);
        start_instr(16'd0, 16'd1);
        check_eq("busy_after_start", 64'(busy), 64'd1);
        wait_done("t1_done", 60);
        check_eq("t1_busy_at_done", 64'(busy), 64'd1);
        @(negedge clk); #1;
        check_eq("t1_busy_after", 64'(busy), 64'd0);
        check_eq("t1_done_single", 64'(done_pulse), 64'd0);
        check_eq("t1_entries", 64'(sb_idx), 64'd8);
        check_eq("t1_rd_latency", 64'(first_rd_cyc - start_cyc), 64'd1);
        check_eq("t1_vld_latency", 64'(first_vld_cyc - start_cyc), 64'd3);
        check_eq("t1_throughput", 64'(last_hs_cyc - first_hs_cyc), 64'd7);
        check_eq("split_bias", 64'(first_bias), 64'hFFFF_FFF6);
        check_eq("split_scale", 64'(first_scale), 64'h100);
        check_eq("t1_outstanding", 64'(max_out <= BUF_DEPTH), 64'd1);

        // Backpressure 1,0,0,1
        load_fifo(8, 32'hB000_0000);
        sb_reset(8);
        bp_mode = 1'b1;
        start_instr(16'd0, 16'd1);
        wait_done("bp_done", 150);
        bp_mode = 1'b0;
        #1;
        check_eq("bp_entries", 64'(sb_idx), 64'd8);
        check_eq("bp_outstanding", 64'(max_out <= BUF_DEPTH), 64'd1);

        // FIFO reports empty for 5 cycles mid-run
        load_fifo(8, 32'hC000_0000);
        sb_reset(8);
        start_instr(16'd0, 16'd1);
        @(posedge clk); #1;
        force_empty = 1'b1;
        hi_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i > 0 && fifo_rd_en) hi_cnt++;
        end
        @(posedge clk); #1;
        force_empty = 1'b0;
        check_eq("empty_no_read", 64'(hi_cnt), 64'd0);
        wait_done("empty_done", 80);
        #1;
        check_eq("empty_entries", 64'(sb_idx), 64'd8);

        // Reset at entry 3 of 8, then a clean restart
        load_fifo(8, 32'hD000_0000);
        sb_reset(8);
        start_instr(16'd0, 16'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (sb_idx >= 3) break;
        end
        check_eq("rst_mid_reached", 64'(sb_idx), 64'd3);
        dc_before = done_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_busy", 64'(busy), 64'd0);
        check_eq("mid_rst_vld", 64'(bias_vld), 64'd0);
        check_eq("mid_rst_rd_en", 64'(fifo_rd_en), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("mid_rst_no_done", 64'(done_cnt), 64'(dc_before));
        check_eq("mid_rst_m_idx", 64'(m_idx), 64'd0);
        load_fifo(8, 32'hE000_0000);
        sb_reset(8);
        start_instr(16'd0, 16'd1);
        wait_done("restart_done", 60);
        #1;
        check_eq("restart_entries", 64'(sb_idx), 64'd8);

`ifdef CONV_BIAS_RD_CHK_EN
        // Residual bias: 9 entries for T=8
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        check_eq("err_after_rst", 64'(err), 64'd0);
        load_fifo(9, 32'hF000_0000);
        sb_reset(8);
        start_instr(16'd0, 16'd1);
        wait_done("chk_res_done", 60);
        check_eq("err_before_done_end", 64'(err), 64'd0);
        @(negedge clk);
        check_eq("err_residual", 64'(err), 64'd1);

        // Second start while RUN
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        check_eq("err_cleared", 64'(err), 64'd0);
        load_fifo(8, 32'h1000_0000);
        sb_reset(8);
        start_instr(16'd0, 16'd1);
        @(posedge clk); #1; start_pulse = 1'b1;
        @(posedge clk); #1; start_pulse = 1'b0;
        @(negedge clk);
        check_eq("err_restart", 64'(err), 64'd1);
        wait_done("chk_restart_done", 60);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_bias_fifo_rd.md
# conv_bias_fifo_rd

Consumer side of the convolution Bias FIFO. It pops 64-bit bias entries that the bias writer has pushed, splits each into a bias and a requantization-scale field, and delivers them one per output channel to the post-processing stage over a valid/ready handshake. Each delivered entry carries channel and round tags. The block runs one convolution instruction per `start_pulse` and pulses `done_pulse` after the final entry is consumed.

## Interface
- `M`, default `` `M ``: output channels per W round; entries per (x, w) round.
- `BUF_DEPTH`, default 4: internal buffer entries; power of 2, at least 4.
- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_pulse` in 1: single-cycle instruction start.
- `n_X_rnd_minus_1` in 16: number of X rounds minus 1.
- `n_W_rnd_minus_1` in 16: number of W rounds minus 1.
- `fifo_rd_en` out 1: Bias FIFO pop. The FIFO is standard mode: `fifo_dout` is valid the cycle after `fifo_rd_en`.
- `fifo_dout` in 64: FIFO read data.
- `fifo_empty` in 1: FIFO empty flag.
- `bias_vld` out 1: output entry valid.
- `bias_rdy` in 1: downstream accept.
- `bias` out 32: signed bias, from `fifo_dout[31:0]`.
- `scale` out 32: requantization scale, from `fifo_dout[63:32]`.
- `m_idx` out clog2(M): channel index of the presented entry.
- `last_m` out 1: presented entry has `m_idx==M-1`.
- `last` out 1: presented entry is the final entry of the instruction.
- `busy` out 1: high from the cycle after `start_pulse` until `done_pulse`, inclusive.
- `done_pulse` out 1: single-cycle pulse, one cycle after the final handshake.

## Operation
- Total entries per instruction: `T = (n_X_rnd_minus_1+1)*(n_W_rnd_minus_1+1)*M`. Use a 32-bit product. Entries arrive in (x, w, m) order with m fastest.
- FSM states:
  - IDLE: `start_pulse` loads `rd_left=T` and `out_left=T`, clears `m_idx`, then goes to RUN.
  - RUN: issues reads. Moves to DRAIN when `rd_left` reaches 0.
  - DRAIN: waits for `out_left` to reach 0, then goes to DONE.
  - DONE: asserts `done_pulse` for one cycle, then returns to IDLE.
- `start_pulse` outside IDLE is ignored.
- Read issue: `fifo_rd_en` is registered. It is set when `state==RUN && ~fifo_empty && rd_left!=0 && credit!=0`, where `credit = BUF_DEPTH - occupancy - reads_in_flight`. Each issued read decrements `rd_left`.
- The data for a read issued in cycle t is written into the buffer at the end of cycle t+1.
- Output is the buffer head. A handshake (`bias_vld && bias_rdy`) pops the head, decrements `out_left`, and advances `m_idx`, which wraps from M-1 to 0.
- `last` is high when `out_left==1`.
- A simultaneous buffer write and pop in the same cycle leaves occupancy unchanged.
- `bias_vld` stays high with stable data until accepted. `bias_rdy` low never drops entries.

## Timing
- Reset values: `fifo_rd_en=0`, `bias_vld=0`, `bias=0`, `scale=0`, `m_idx=0`, `last_m=0`, `last=0`, `busy=0`, `done_pulse=0`, FSM in IDLE, buffer empty.
- Latency: with `start_pulse` at cycle 0 and a non-empty FIFO, `fifo_rd_en` rises at cycle 1 and `bias_vld` at cycle 3.
- Throughput: 1 entry/cycle sustained with `bias_rdy` held high and the FIFO non-empty.
- `fifo_empty` high stalls issue only; reads already in flight still land.
- Reset asserted mid-instruction: state, counters and buffer clear immediately; `done_pulse` is not generated.

## Configuration
- `CONV_BIAS_RD_CHK_EN` defined: adds output `err` (1 bit, sticky, cleared only by reset). `err` sets on any of:
  - `start_pulse` outside IDLE;
  - `fifo_rd_en` while `fifo_empty`;
  - `~fifo_empty` sampled in the DONE cycle, meaning residual bias.
- Without the macro: no `err` port and no check logic.

## Structure
- Shared package/include: bias entry field offsets (bias [31:0], scale [63:32]), FSM state encoding, and the 32-bit total-count width.
- One sub-module: `conv_bias_buf`, a `BUF_DEPTH`-entry register FIFO with occupancy output. Credit and FSM logic stay in the top level.

## Test plan
- `M=4`, nX−1=0, nW−1=1, FIFO preloaded with 8 entries, `bias_rdy=1`:
  - 8 back-to-back entries out;
  - `m_idx` sequence 0,1,2,3,0,1,2,3;
  - `last_m` on entries 4 and 8, `last` on entry 8;
  - `done_pulse` one cycle after the last handshake.
- Data split: `fifo_dout=64'h0000_0100_FFFF_FFF6` → `bias=-10`, `scale=256`.
- Backpressure: `bias_rdy` toggling 1,0,0,1 → no entry lost or duplicated, data stable while stalled, no more than `BUF_DEPTH` reads outstanding.
- FIFO empty for 5 cycles mid-run → `fifo_rd_en` stays low throughout; order is preserved after refill.
- `rst_n` pulled low at entry 3 of 8, then a new start → block restarts cleanly with `m_idx=0`.
- With `CONV_BIAS_RD_CHK_EN`: 9 entries preloaded for T=8 → `err=1` after DONE; a second `start_pulse` in RUN also sets `err`.
